// File: rtl/reg_wr_arbiter_pkg.sv
// reg_wr_arbiter_pkg: FSM state type and default sizes shared by the register write arbiter.
package reg_wr_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} arb_state_e;
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 32;
endpackage

// File: rtl/reg_wr_arbiter_register.sv
// reg_wr_arbiter_register: enabled register with async active-high clear.
module reg_wr_arbiter_register
    import reg_wr_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else if (en_i) q_q <= d_i;
    end
    assign q_o = q_q;
endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter granting one requester at a time write access to a shared register,
// with an optional lock that keeps the grant across consecutive writes.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          lock_i,
    input  logic [NREQ*WIDTH-1:0]    wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [$clog2(NREQ)-1:0]  owner_o,
    output logic                     busy_o,
    output logic                     wr_o,
    output logic [WIDTH-1:0]         q_o
);
    localparam int OW = $clog2(NREQ);
    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, rot, onehot;
    logic [OW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, off, win;
    logic [2*NREQ-1:0] dbl;
    logic [OW:0]     sum;
    logic            own_req, own_lock, start, rel;
    assign own_req  = req_i[owner_q];
    assign own_lock = lock_i[owner_q];
    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        dbl = {req_i, req_i} >> rr_ptr_q;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = OW'(i);
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        win = (sum >= (OW+1)'(NREQ)) ? OW'(sum - (OW+1)'(NREQ)) : sum[OW-1:0];
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (|req_i ? GRANT : IDLE) : ((own_req && own_lock) ? LOCK : IDLE);
    end
    always_comb begin
        busy_o   = state_q != IDLE;
        wr_o     = busy_o && own_req;
        start    = state_q == IDLE && |req_i;
        rel      = busy_o && state_d == IDLE;
        gnt_d    = start ? onehot : rel ? '0 : gnt_q;
        owner_d  = start ? win : rel ? '0 : owner_q;
        rr_ptr_d = rel ? ((owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1) : rr_ptr_q;
    end
    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    reg_wr_arbiter_register #(.WIDTH(WIDTH)) register (
        .clk  (clk),
        .rst  (rst),
        .en_i (wr_o),
        .d_i  (wdata_i[owner_q*WIDTH +: WIDTH]),
        .q_o  (q_o)
    );
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed scenarios plus a random invariant run for reg_wr_arbiter.
module tb_reg_wr_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 32;
    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_i = '0;
    logic [NREQ-1:0]       lock_i = '0;
    logic [NREQ*WIDTH-1:0] wdata_i = '0;
    logic [NREQ-1:0]       gnt_o;
    logic [1:0]            owner_o;
    logic                  busy_o;
    logic                  wr_o;
    logic [WIDTH-1:0]      q_o;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .owner_o(owner_o), .busy_o(busy_o), .wr_o(wr_o), .q_o(q_o)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_i = '0;
        lock_i = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt_o); end
        tests++; if (owner_o !== 2'd0) begin fails++; $display("FAIL reset_owner got %0d want 0", owner_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
        tests++; if (q_o !== 32'h0) begin fails++; $display("FAIL reset_q got %h want 0", q_o); end
        tests++; if (wr_o !== 1'b0) begin fails++; $display("FAIL reset_wr got %b want 0", wr_o); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            cyc(); req_i = 4'b1111; #1;
            tests++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin fails++; $display("FAIL rr_gap%0d got gnt=%b busy=%b want 0000/0", k, gnt_o, busy_o); end
            cyc(); #1;
            tests++; if (gnt_o !== exp_g || owner_o !== 2'(k % 4)) begin fails++; $display("FAIL rr_gnt%0d got gnt=%b owner=%0d want %b/%0d", k, gnt_o, owner_o, exp_g, k % 4); end
        end
        cyc(); req_i = '0; #1;
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL rr_end got %b want 0000", gnt_o); end
    endtask

    task automatic test_lock();
        cyc(); req_i = 4'b0011; lock_i = 4'b0010; wdata_i[32 +: 32] = 32'h100; #1;
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL lock_idle got %b want 0000", gnt_o); end
        for (int i = 0; i < 5; i++) begin
            cyc(); wdata_i[32 +: 32] = 32'h100 + 32'(i); #1;
            tests++; if (gnt_o !== 4'b0010 || owner_o !== 2'd1 || wr_o !== 1'b1) begin fails++; $display("FAIL lock_hold%0d got gnt=%b owner=%0d wr=%b want 0010/1/1", i, gnt_o, owner_o, wr_o); end
            if (i > 0) begin
                tests++; if (q_o !== 32'h100 + 32'(i - 1)) begin fails++; $display("FAIL lock_q%0d got %h want %h", i, q_o, 32'h100 + 32'(i - 1)); end
            end
        end
        cyc(); req_i = 4'b0001; lock_i = '0; #1;
        tests++; if (q_o !== 32'h104 || busy_o !== 1'b1 || wr_o !== 1'b0 || owner_o !== 2'd1) begin fails++; $display("FAIL lock_drop got q=%h busy=%b wr=%b owner=%0d want 104/1/0/1", q_o, busy_o, wr_o, owner_o); end
        cyc(); wdata_i[0 +: 32] = 32'hBEEF; #1;
        tests++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin fails++; $display("FAIL lock_release got gnt=%b busy=%b want 0000/0", gnt_o, busy_o); end
        cyc(); #1;
        tests++; if (gnt_o !== 4'b0001 || owner_o !== 2'd0 || wr_o !== 1'b1) begin fails++; $display("FAIL lock_next got gnt=%b owner=%0d wr=%b want 0001/0/1", gnt_o, owner_o, wr_o); end
        cyc(); req_i = '0; #1;
        tests++; if (q_o !== 32'hBEEF || gnt_o !== 4'b0000) begin fails++; $display("FAIL lock_final got q=%h gnt=%b want beef/0000", q_o, gnt_o); end
    endtask

    task automatic test_single();
        cyc(); req_i = 4'b0100; wdata_i[64 +: 32] = 32'hA5A5A5A5; #1;
        tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL single_idle got %b want 0000", gnt_o); end
        cyc(); #1;
        tests++; if (gnt_o !== 4'b0100 || owner_o !== 2'd2 || wr_o !== 1'b1) begin fails++; $display("FAIL single_gnt got gnt=%b owner=%0d wr=%b want 0100/2/1", gnt_o, owner_o, wr_o); end
        cyc(); req_i = '0; #1;
        tests++; if (q_o !== 32'hA5A5A5A5) begin fails++; $display("FAIL single_q got %h want a5a5a5a5", q_o); end
        tests++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0 || wr_o !== 1'b0) begin fails++; $display("FAIL single_end got gnt=%b busy=%b wr=%b want 0000/0/0", gnt_o, busy_o, wr_o); end
    endtask

    task automatic test_drop_in_grant();
        cyc(); req_i = 4'b1000; wdata_i[96 +: 32] = 32'h12345678; #1;
        cyc(); req_i = '0; #1;
        tests++; if (gnt_o !== 4'b1000 || owner_o !== 2'd3 || busy_o !== 1'b1 || wr_o !== 1'b0) begin fails++; $display("FAIL drop_gnt got gnt=%b owner=%0d busy=%b wr=%b want 1000/3/1/0", gnt_o, owner_o, busy_o, wr_o); end
        cyc(); req_i = 4'b1001; #1;
        tests++; if (q_o !== 32'hA5A5A5A5 || gnt_o !== 4'b0000) begin fails++; $display("FAIL drop_q got q=%h gnt=%b want a5a5a5a5/0000", q_o, gnt_o); end
        cyc(); #1;
        tests++; if (gnt_o !== 4'b0001 || owner_o !== 2'd0) begin fails++; $display("FAIL drop_wrap got gnt=%b owner=%0d want 0001/0", gnt_o, owner_o); end
        cyc(); req_i = '0; #1;
    endtask

    task automatic test_reset_mid_lock();
        cyc(); req_i = 4'b0001; lock_i = 4'b0001; wdata_i[0 +: 32] = 32'h55; #1;
        cyc(); #1;
        cyc(); #1;
        tests++; if (busy_o !== 1'b1 || q_o !== 32'h55 || gnt_o !== 4'b0001) begin fails++; $display("FAIL rstlock_pre got busy=%b q=%h gnt=%b want 1/55/0001", busy_o, q_o, gnt_o); end
        #1 rst = 1'b1;
        #1;
        tests++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0 || q_o !== 32'h0 || owner_o !== 2'd0) begin fails++; $display("FAIL rstlock_async got gnt=%b busy=%b q=%h owner=%0d want 0000/0/0/0", gnt_o, busy_o, q_o, owner_o); end
        @(posedge clk); #1;
        tests++; if (q_o !== 32'h0 || wr_o !== 1'b0) begin fails++; $display("FAIL rstlock_hold got q=%h wr=%b want 0/0", q_o, wr_o); end
        cyc(); rst = 1'b0; req_i = 4'b1000; lock_i = '0; #1;
        cyc(); #1;
        tests++; if (gnt_o !== 4'b1000 || owner_o !== 2'd3) begin fails++; $display("FAIL rstlock_after got gnt=%b owner=%0d want 1000/3", gnt_o, owner_o); end
        cyc(); req_i = '0; #1;
    endtask

    task automatic test_random();
        logic [31:0] exp_q;
        logic [3:0]  exp_g;
        logic        exp_wr;
        int          idx;
        cyc(); rst = 1'b1; req_i = '0; lock_i = '0; #1;
        cyc(); rst = 1'b0;
        exp_q = 32'h0;
        for (int n = 0; n < 10000; n++) begin
            cyc();
            req_i = 4'($urandom_range(0, 15));
            lock_i = 4'($urandom_range(0, 15));
            wdata_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            idx = 0;
            for (int b = 0; b < 4; b++) if (gnt_o[b]) idx = b;
            exp_g = busy_o ? 4'b0001 << owner_o : 4'b0000;
            exp_wr = busy_o && |(req_i & gnt_o);
            tests++; if (gnt_o !== exp_g || (busy_o && !$onehot(gnt_o))) begin fails++; $display("FAIL rand_gnt%0d got gnt=%b busy=%b owner=%0d want %b", n, gnt_o, busy_o, owner_o, exp_g); end
            tests++; if (wr_o !== exp_wr) begin fails++; $display("FAIL rand_wr%0d got %b want %b", n, wr_o, exp_wr); end
            tests++; if (q_o !== exp_q) begin fails++; $display("FAIL rand_q%0d got %h want %h", n, q_o, exp_q); end
            if (exp_wr) exp_q = wdata_i[idx*32 +: 32];
        end
        cyc(); req_i = '0; lock_i = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_single();
        test_drop_in_grant();
        test_reset_mid_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
